avg_channel_scheduler: RTL and testbench

Round-robin scheduler that time-shares one two-tap averaging datapath among NUM_CH sample streams. Each channel offers samples through a valid/ready handshake. The block grants one channel per cycle and keeps a per-channel last-sample context. It produces (sample + previous sample of the same channel) >> 1, tagged with the channel index, using the same 2-cycle ce-to-o_ce latency as the single-channel average filter. It sits between the multi-channel ADC front end and the downstream per-channel consumers.

---
 rtl/avg_channel_scheduler.sv | 97 +++++++++
 tb/tb_avg_channel_scheduler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/avg_channel_scheduler.sv
// Round-robin scheduler sharing one two-tap averager among NUM_CH sample streams.
// Keeps a per-channel previous-sample context and emits (x + x_prev) >> 1 tagged with its channel.
module avg_channel_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_enable,
    input  logic [NUM_CH-1:0]            i_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
    input  logic [NUM_CH-1:0]            i_clear,
    output logic [NUM_CH-1:0]            o_ready,
    output logic                         o_ce,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic [CH_W-1:0]              o_ch,
    output logic                         o_busy
);

    logic [CH_W-1:0]       ptr;
    logic [CH_W-1:0]       ptr_next;
    logic [CH_W-1:0]       gnt_idx;
    logic                  gnt_found;
    logic                  accept;
    logic [DATA_WIDTH-1:0] data_g;
    logic [DATA_WIDTH-1:0] ctx_eff;
    logic [DATA_WIDTH-1:0] ctx [NUM_CH];

    logic                  s1_ce;
    logic [DATA_WIDTH:0]   s1_sum;
    logic [CH_W-1:0]       s1_ch;

    // Channel index ptr+off wrapped into 0..NUM_CH-1; both operands are below NUM_CH.
    function automatic logic [CH_W-1:0] wrap_idx(input logic [CH_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_CH) sum = sum - NUM_CH;
        return CH_W'(sum);
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!gnt_found && i_valid[wrap_idx(ptr, i)]) begin
                gnt_found = 1'b1;
                gnt_idx   = wrap_idx(ptr, i);
            end
        end
    end

    assign accept   = i_enable & gnt_found;
    assign ptr_next = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
    assign data_g   = i_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    // A clear arriving with the accept makes this sample behave like a channel's first.
    assign ctx_eff  = i_clear[gnt_idx] ? '0 : ctx[gnt_idx];
    assign o_busy   = s1_ce | o_ce;

    always_comb begin
        o_ready = '0;
        if (reset_n && accept) o_ready[gnt_idx] = 1'b1;
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr    <= '0;
            s1_ce  <= 1'b0;
            s1_sum <= '0;
            s1_ch  <= '0;
            o_ce   <= 1'b0;
            o_data <= '0;
            o_ch   <= '0;
            // NOTE: the context array is reset explicitly because a channel's first sample must average with 0.
            for (int c = 0; c < NUM_CH; c++) ctx[c] <= '0;
        end else begin
            s1_ce <= accept;
            if (accept) begin
                ptr    <= ptr_next;
                s1_sum <= {1'b0, data_g} + {1'b0, ctx_eff};
                s1_ch  <= gnt_idx;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (accept && gnt_idx == CH_W'(c)) ctx[c] <= data_g;
                else if (i_clear[c])               ctx[c] <= '0;
            end
            o_ce <= s1_ce;
            if (s1_ce) begin
                o_data <= s1_sum[DATA_WIDTH:1];
                o_ch   <= s1_ch;
            end
        end
    end

endmodule

// File: tb/tb_avg_channel_scheduler.sv
// Self-checking bench for avg_channel_scheduler: directed scenarios plus random traffic,
// compared against a transaction-level model of arbitration, context and the 2-edge result pipe.
module tb_avg_channel_scheduler;

    localparam int DW = 8;
    localparam int NC = 4;
    localparam int CW = 2;

    typedef struct {
        bit ce;
        int data;
        int ch;
    } res_t;

    logic              clk;
    logic              reset_n;
    logic              i_enable;
    logic [NC-1:0]     i_valid;
    logic [NC*DW-1:0]  i_data;
    logic [NC-1:0]     i_clear;
    logic [NC-1:0]     o_ready;
    logic              o_ce;
    logic [DW-1:0]     o_data;
    logic [CW-1:0]     o_ch;
    logic              o_busy;

    int   errors = 0;
    int   checks = 0;

    int   ctx_m [NC];
    int   ptr_m;
    res_t s1_m;
    res_t out_m;
    res_t obs_q [$];

    avg_channel_scheduler #(.DATA_WIDTH(DW), .NUM_CH(NC), .CH_W(CW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_enable (i_enable),
        .i_valid  (i_valid),
        .i_data   (i_data),
        .i_clear  (i_clear),
        .o_ready  (o_ready),
        .o_ce     (o_ce),
        .o_data   (o_data),
        .o_ch     (o_ch),
        .o_busy   (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [NC*DW-1:0] pack(input int c, input int x);
        logic [NC*DW-1:0] p;
        p = '0;
        p[c*DW +: DW] = DW'(x);
        return p;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NC; c++) ctx_m[c] = 0;
        ptr_m = 0;
        s1_m  = '{ce: 1'b0, data: 0, ch: 0};
        out_m = '{ce: 1'b0, data: 0, ch: 0};
    endtask

    // One clock cycle: drive at negedge, check grant, then check registered outputs after the edge.
    task automatic step(input logic en, input logic [NC-1:0] v, input logic [NC*DW-1:0] d,
                        input logic [NC-1:0] clr);
        bit acc;
        int g;
        int c;
        int dg;
        int prev;
        @(negedge clk);
        i_enable = en;
        i_valid  = v;
        i_data   = d;
        i_clear  = clr;
        #1;
        acc = 0;
        g   = 0;
        if (en) begin
            for (int k = 0; k < NC; k++) begin
                c = (ptr_m + k) % NC;
                if (!acc && v[c]) begin
                    acc = 1;
                    g   = c;
                end
            end
        end
        check("ready", o_ready, acc ? (1 << g) : 0);
        @(posedge clk);
        #1;
        out_m.ce = s1_m.ce;
        if (s1_m.ce) begin
            out_m.data = s1_m.data;
            out_m.ch   = s1_m.ch;
        end
        s1_m.ce = acc;
        if (acc) begin
            dg        = int'(d[g*DW +: DW]);
            prev      = clr[g] ? 0 : ctx_m[g];
            s1_m.data = (dg + prev) / 2;
            s1_m.ch   = g;
            ctx_m[g]  = dg;
            ptr_m     = (g + 1) % NC;
        end
        for (int k = 0; k < NC; k++)
            if (clr[k] && !(acc && k == g)) ctx_m[k] = 0;
        check("o_ce",   o_ce,   out_m.ce);
        check("o_data", o_data, out_m.data);
        check("o_ch",   o_ch,   out_m.ch);
        check("o_busy", o_busy, s1_m.ce | out_m.ce);
        if (o_ce === 1'b1) obs_q.push_back('{ce: 1'b1, data: int'(o_data), ch: int'(o_ch)});
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, '0, '0, '0);
    endtask

    // Reset asserted at a negedge; requests stay raised to prove o_ready is masked.
    task automatic apply_reset(input int cycles);
        @(negedge clk);
        reset_n  = 1'b0;
        i_enable = 1'b1;
        i_valid  = '1;
        i_clear  = '0;
        model_reset();
        repeat (cycles) begin
            #1;
            check("rst_ready", o_ready, 0);
            check("rst_ce",    o_ce,    0);
            check("rst_data",  o_data,  0);
            check("rst_ch",    o_ch,    0);
            check("rst_busy",  o_busy,  0);
            @(negedge clk);
        end
        reset_n = 1'b1;
        i_valid = '0;
    endtask

    initial begin
        reset_n  = 1'b0;
        i_enable = 1'b0;
        i_valid  = '0;
        i_data   = '0;
        i_clear  = '0;
        model_reset();

        // Reset state and quiet outputs after release
        apply_reset(3);
        idle(5);

        // Single channel: 100 then 50 on ch1
        obs_q.delete();
        step(1'b1, 4'b0010, pack(1, 100), '0);
        step(1'b1, 4'b0010, pack(1, 50), '0);
        idle(3);
        check("single_n", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            check("single_d0", obs_q[0].data, 50);
            check("single_c0", obs_q[0].ch, 1);
            check("single_d1", obs_q[1].data, 75);
            check("single_c1", obs_q[1].ch, 1);
        end

        // Round robin from pointer 0 with every channel requesting
        apply_reset(1);
        obs_q.delete();
        repeat (5) step(1'b1, 4'b1111, {8'd40, 8'd30, 8'd20, 8'd10}, '0);
        idle(3);
        check("rr_n", obs_q.size(), 5);
        if (obs_q.size() == 5) begin
            for (int k = 0; k < 5; k++) check("rr_ch", obs_q[k].ch, k % NC);
            check("rr_d4", obs_q[4].data, 10);
        end

        // Full-scale samples must not wrap the sum
        apply_reset(1);
        obs_q.delete();
        step(1'b1, 4'b0100, pack(2, 255), '0);
        step(1'b1, 4'b0100, pack(2, 255), '0);
        idle(3);
        check("ovf_n", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            check("ovf_d0", obs_q[0].data, 127);
            check("ovf_d1", obs_q[1].data, 255);
        end

        // Clear colliding with an accept on the same channel
        obs_q.delete();
        step(1'b1, 4'b0001, pack(0, 200), '0);
        step(1'b1, 4'b0001, pack(0, 40), 4'b0001);
        step(1'b1, 4'b0001, pack(0, 60), '0);
        idle(3);
        check("clr_n", obs_q.size(), 3);
        if (obs_q.size() == 3) begin
            check("clr_d1", obs_q[1].data, 20);
            check("clr_d2", obs_q[2].data, 50);
        end

        // Reset while a ch3 sample is in flight
        obs_q.delete();
        step(1'b1, 4'b1000, pack(3, 200), '0);
        apply_reset(1);
        idle(4);
        check("midrst_quiet", obs_q.size(), 0);
        step(1'b1, 4'b1000, pack(3, 80), '0);
        idle(3);
        check("midrst_n", obs_q.size(), 1);
        if (obs_q.size() == 1) begin
            check("midrst_d", obs_q[0].data, 40);
            check("midrst_c", obs_q[0].ch, 3);
        end

        // Random traffic: enable gaps, sparse clears, arbitrary request patterns
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 5) != 0,
                 NC'($urandom),
                 (NC*DW)'($urandom),
                 ($urandom_range(0, 7) == 0) ? NC'($urandom) : '0);
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
